right_shift: RTL and testbench
==============================

// Module: right_shift
// PURPOSE
// Registered 32-bit logical right shifter in the datapath; feeds ALU result mux.
// Shifts operand A right by the unsigned amount in B, zero-filling from the MSB.
// One pipeline register stage between operands and result; async active-low reset.
// PARAMETERS
// none (data width fixed at 32; shift stages fixed at 5)
// PORTS
// clk             in   1   rising-edge clock (single clock domain)
// rst_n           in   1   asynchronous reset, active-low
// in_valid        in   1   A/B valid this cycle; sampled at rising clk edge
// A               in   32  operand to be shifted (bit pattern, sign ignored)
// B               in   32  shift amount, full 32-bit unsigned value
// out_valid       out  1   RightShifted_A holds result of an accepted operation
// RightShifted_A  out  32  registered result: A >> B (logical)
// BEHAVIOUR
// - Reset: rst_n low asynchronously forces RightShifted_A=32'h0, out_valid=0;
//   held while low; first capture on first rising clk after rst_n rises.
// - Function: result = (B >= 32) ? 32'h0 : (A >> B[4:0]); vacated bits are 0.
// - Whole B is significant: any set bit in B[31:5] forces result 0 (no wrap of
//   shift amount modulo 32; e.g. B=143 or B=32 -> 0, never A>>15 or A>>0).
// - Structure: 5-stage combinational barrel (shift by 16,8,4,2,1 under B[4..0])
//   plus saturation detect (|B[31:5]) that zeroes output; then output register.
// - Latency: exactly 1 cycle. If in_valid=1 at edge n, RightShifted_A and
//   out_valid=1 are visible after edge n; out_valid=0 after an edge with in_valid=0.
// - in_valid=0: RightShifted_A holds its previous value (register not loaded).
// - B=0: result equals A unchanged. B=31: result = {31'b0, A[31]}.
// - No backpressure; a new operation can be accepted every cycle (throughput 1).
// - Reset asserted mid-operation: pending result discarded, outputs go to 0 at once.
// - No X propagation: all outputs defined from reset onward.
// TESTING
// - Reset: rst_n=0 with A=32'hFFFFFFFF,B=0,in_valid=1 -> RightShifted_A=0, out_valid=0.
// - A=1000000007 (32'h3B9ACA07), B=143 -> 32'h00000000 one cycle later, out_valid=1.
// - A=-999999993 (32'hC4653607), B=32 -> 32'h00000000 (boundary, no wrap).
// - A=1000245 (32'h000F4335), B=13 -> 32'h0000007A (122).
// - A=-999755 (32'hFFF0BEB5), B=7 -> 32'h01FFE17D (zero fill, not sign fill).
// - A=32'h80000001: B=0 -> 32'h80000001; B=31 -> 32'h1; then in_valid=0 -> value holds, out_valid=0.

Source files
------------

// File: rtl/right_shift_if.sv
// Operand/result bundle for the registered 32-bit logical right shifter.
// The master drives the operands; the slave returns the registered result.
interface right_shift_if;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic [31:0] RightShifted_A;

  modport master (
    output in_valid, A, B,
    input  out_valid, RightShifted_A
  );

  modport slave (
    input  in_valid, A, B,
    output out_valid, RightShifted_A
  );
endinterface

// File: rtl/right_shift.sv
// Registered 32-bit logical right shifter: five-stage barrel plus saturation to
// zero for shift amounts of 32 or more, followed by a single output register.
module right_shift (
  input  logic        clk,
  input  logic        rst_n,
  right_shift_if.slave bus
);

  logic [31:0] w_s16;
  logic [31:0] w_s8;
  logic [31:0] w_s4;
  logic [31:0] w_s2;
  logic [31:0] w_s1;
  logic        w_sat;
  logic [31:0] w_result;

  logic [31:0] r_result;
  logic        r_valid;

  assign w_s16 = bus.B[4] ? {16'b0, bus.A[31:16]} : bus.A;
  assign w_s8  = bus.B[3] ? {8'b0,  w_s16[31:8]}  : w_s16;
  assign w_s4  = bus.B[2] ? {4'b0,  w_s8[31:4]}   : w_s8;
  assign w_s2  = bus.B[1] ? {2'b0,  w_s4[31:2]}   : w_s4;
  assign w_s1  = bus.B[0] ? {1'b0,  w_s2[31:1]}   : w_s2;

  // Any bit above B[4] means a shift of 32 or more: result is all zeros, never
  // a wrapped shift of B mod 32.
  assign w_sat    = |bus.B[31:5];
  assign w_result = w_sat ? 32'h0 : w_s1;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= 32'h0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_result <= w_result;
      end
    end
  end

  assign bus.RightShifted_A = r_result;
  assign bus.out_valid      = r_valid;

endmodule

// File: tb/tb_right_shift.sv
// Directed self-checking bench for right_shift with hand-computed expectations.
module tb_right_shift;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  right_shift_if bus ();

  right_shift dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one operation, clock it, then check result and valid after the edge.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    #1;
    check({tag, "_data"}, bus.RightShifted_A, exp);
    check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'h1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset held low with a valid operation presented: outputs stay zero.
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.A        = 32'hFFFF_FFFF;
    bus.B        = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", bus.RightShifted_A, 32'h0);
    check("rst_valid", {31'b0, bus.out_valid}, 32'h0);

    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;

    apply("b143",     32'h3B9A_CA07, 32'd143,        32'h0000_0000);
    apply("b32",      32'hC465_3607, 32'd32,         32'h0000_0000);
    apply("b13",      32'h000F_4335, 32'd13,         32'h0000_007A);
    apply("b7_zfill", 32'hFFF0_BEB5, 32'd7,          32'h01FF_E17D);
    apply("b1",       32'hDEAD_BEEF, 32'd1,          32'h6F56_DF77);
    apply("b2",       32'hDEAD_BEEF, 32'd2,          32'h37AB_6FBB);
    apply("b4",       32'hDEAD_BEEF, 32'd4,          32'h0DEA_DBEE);
    apply("b8",       32'hDEAD_BEEF, 32'd8,          32'h00DE_ADBE);
    apply("b16",      32'hDEAD_BEEF, 32'd16,         32'h0000_DEAD);
    apply("b33",      32'hDEAD_BEEF, 32'd33,         32'h0000_0000);
    apply("bmsb",     32'hDEAD_BEEF, 32'h8000_0000,  32'h0000_0000);
    apply("ball",     32'hDEAD_BEEF, 32'hFFFF_FFFF,  32'h0000_0000);
    apply("b0",       32'h8000_0001, 32'd0,          32'h8000_0001);
    apply("b31",      32'h8000_0001, 32'd31,         32'h0000_0001);

    // in_valid low: result register holds, out_valid drops.
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A        = 32'hFFFF_FFFF;
    bus.B        = 32'd0;
    @(posedge clk);
    #1;
    check("hold_data", bus.RightShifted_A, 32'h0000_0001);
    check("hold_valid", {31'b0, bus.out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("hold2_data", bus.RightShifted_A, 32'h0000_0001);

    // Reset asserted mid-cycle after a capture: outputs clear before the next edge.
    apply("pre_rst", 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_data", bus.RightShifted_A, 32'h0);
    check("midrst_valid", {31'b0, bus.out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst", 32'h1234_5678, 32'd4, 32'h0123_4567);

    @(negedge clk);
    bus.in_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
